// File: rtl/trg_ack_sequencer.sv
// Trigger/acknowledge sequencer: drives masked TRG lines in pulse or level
// mode, then collects synchronised ACK edges with timeout and latency.
module trg_ack_sequencer #(
  parameter int N_CH        = 12,
  parameter int PW_W        = 8,
  parameter int TO_W        = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic            BOARD_CLOCK,
  input  logic            RST,
  input  logic            START_I,
  input  logic [N_CH-1:0] MASK_I,
  input  logic            MODE_I,
  input  logic [PW_W-1:0] PW_I,
  input  logic [TO_W-1:0] TIMEOUT_I,
  input  logic            ABORT_I,
  input  logic [N_CH-1:0] ACK,
  output logic [N_CH-1:0] TRG,
  output logic            BUSY_O,
  output logic            DONE_O,
  output logic [N_CH-1:0] ACK_SEEN_O,
  output logic [N_CH-1:0] TMO_O,
  output logic [TO_W-1:0] LAT_O
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PULSE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t state;

  logic [SYNC_STAGES-1:0][N_CH-1:0] sync_q;
  logic [N_CH-1:0] ack_s;
  logic [N_CH-1:0] ack_d;
  logic [N_CH-1:0] ack_rise;

  logic [N_CH-1:0] mask_q;
  logic            mode_q;
  logic [PW_W-1:0] pw_q;
  logic [TO_W-1:0] to_q;
  logic [TO_W-1:0] e_q;
  logic [TO_W-1:0] e_nxt;

  logic            active;
  logic [N_CH-1:0] seen_nxt;
  logic            covered;
  logic            done_ok;
  logic            tmo_hit;

  assign ack_s    = sync_q[SYNC_STAGES-1];
  assign ack_rise = ack_s & ~ack_d;

  always_ff @(posedge BOARD_CLOCK or negedge RST) begin
    if (!RST) begin
      sync_q <= '0;
      ack_d  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ACK};
      ack_d  <= ack_s;
    end
  end

  assign active = (state == S_PULSE) || (state == S_WAIT);

  always_comb begin
    seen_nxt = ACK_SEEN_O;
    if (active) seen_nxt = ACK_SEEN_O | (ack_rise & mask_q);
  end

  // A final ack landing on the timeout cycle counts as coverage.
  assign covered = ((seen_nxt & mask_q) == mask_q);
  assign done_ok = (state == S_WAIT) &&
                   ((ACK_SEEN_O & mask_q) == mask_q);
  assign tmo_hit = (to_q != '0) && (e_q >= to_q) && !covered;
  assign e_nxt   = (&e_q) ? e_q : e_q + TO_W'(1);

  assign BUSY_O = (state != S_IDLE);

  always_ff @(posedge BOARD_CLOCK or negedge RST) begin
    if (!RST) begin
      state      <= S_IDLE;
      TRG        <= '0;
      DONE_O     <= 1'b0;
      ACK_SEEN_O <= '0;
      TMO_O      <= '0;
      LAT_O      <= '0;
      mask_q     <= '0;
      mode_q     <= 1'b0;
      pw_q       <= '0;
      to_q       <= '0;
      e_q        <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          DONE_O <= 1'b0;
          TRG    <= '0;
          if (START_I) begin
            mask_q     <= MASK_I;
            mode_q     <= MODE_I;
            pw_q       <= (PW_I == '0) ? '0 : PW_I - PW_W'(1);
            to_q       <= TIMEOUT_I;
            e_q        <= '0;
            ACK_SEEN_O <= '0;
            TMO_O      <= '0;
            LAT_O      <= '0;
            if (MASK_I == '0) begin
              state  <= S_DONE;
              DONE_O <= 1'b1;
            end else begin
              TRG   <= MASK_I;
              state <= MODE_I ? S_WAIT : S_PULSE;
            end
          end
        end
        S_PULSE, S_WAIT: begin
          if (ABORT_I) begin
            state <= S_IDLE;
            TRG   <= '0;
          end else begin
            ACK_SEEN_O <= seen_nxt;
            e_q        <= e_nxt;
            if (done_ok) begin
              state  <= S_DONE;
              DONE_O <= 1'b1;
              LAT_O  <= e_q;
              TRG    <= '0;
            end else if (tmo_hit) begin
              state  <= S_DONE;
              DONE_O <= 1'b1;
              TMO_O  <= mask_q & ~seen_nxt;
              LAT_O  <= '1;
              TRG    <= '0;
            end else if (state == S_PULSE) begin
              if (pw_q == '0) begin
                state <= S_WAIT;
                TRG   <= '0;
              end else begin
                pw_q <= pw_q - PW_W'(1);
              end
            end else begin
              TRG <= mode_q ? (mask_q & ~seen_nxt) : '0;
            end
          end
        end
        S_DONE: begin
          DONE_O <= 1'b0;
          TRG    <= '0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trg_ack_sequencer.sv
// Directed bench for trg_ack_sequencer; sequence results are queued at
// start and checked by a monitor whenever DONE_O pulses.
module tb_trg_ack_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [11:0] mask;
  logic        mode;
  logic [7:0]  pw;
  logic [15:0] tmo_cfg;
  logic        abort;
  logic [11:0] ack;
  logic [11:0] trg;
  logic        busy;
  logic        done;
  logic [11:0] seen;
  logic [11:0] tmo;
  logic [15:0] lat;

  trg_ack_sequencer dut (
    .BOARD_CLOCK(clk),
    .RST(rst_n),
    .START_I(start),
    .MASK_I(mask),
    .MODE_I(mode),
    .PW_I(pw),
    .TIMEOUT_I(tmo_cfg),
    .ABORT_I(abort),
    .ACK(ack),
    .TRG(trg),
    .BUSY_O(busy),
    .DONE_O(done),
    .ACK_SEEN_O(seen),
    .TMO_O(tmo),
    .LAT_O(lat)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [11:0] seen;
    logic [11:0] tmo;
    logic [15:0] lat;
  } exp_t;

  exp_t exp_q[$];
  exp_t got;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)",
               name, act, want, cyc);
    end
  endtask

  task automatic push(input int id, input logic [11:0] s,
                      input logic [11:0] t, input logic [15:0] l);
    exp_t e;
    e.id = id; e.seen = s; e.tmo = t; e.lat = l;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done got=1 want=0 (cycle %0d)", cyc);
      end else begin
        got = exp_q.pop_front();
        chk($sformatf("seq%0d_seen", got.id), 32'(seen), 32'(got.seen));
        chk($sformatf("seq%0d_tmo", got.id), 32'(tmo), 32'(got.tmo));
        chk($sformatf("seq%0d_lat", got.id), 32'(lat), 32'(got.lat));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Called at a negedge; returns at the negedge of cycle 1.
  task automatic go(input logic [11:0] m, input logic md,
                    input logic [7:0] p, input logic [15:0] t);
    start = 1'b1; mask = m; mode = md; pw = p; tmo_cfg = t;
    cyc = 0;
    tick();
    start = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; mask = '0; mode = 1'b0;
    pw = '0; tmo_cfg = '0; abort = 1'b0; ack = '0;
    idle(3);
    chk("rst_trg", 32'(trg), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_seen", 32'(seen), 0);
    chk("rst_tmo", 32'(tmo), 0);
    chk("rst_lat", 32'(lat), 0);
    rst_n = 1'b1;
    idle(3);

    // pulse mode, four channels acked together
    push(1, 12'h00F, 12'h000, 16'd12);
    go(12'h00F, 1'b0, 8'd4, 16'd0);
    chk("t1_trg_c1", 32'(trg), 32'h00F);
    chk("t1_busy_c1", 32'(busy), 1);
    run_to(4);  chk("t1_trg_c4", 32'(trg), 32'h00F);
    run_to(5);  chk("t1_trg_c5", 32'(trg), 0);
    run_to(10); ack = 12'h00F;
    run_to(12); chk("t1_seen_c12", 32'(seen), 0);
    run_to(13); chk("t1_seen_c13", 32'(seen), 32'h00F);
    run_to(14); chk("t1_done_c14", 32'(done), 1);
    run_to(15); chk("t1_busy_c15", 32'(busy), 0);
    drain("t1_drain");
    ack = '0; idle(5);

    // level mode, staggered acks
    push(2, 12'h003, 12'h000, 16'd22);
    go(12'h003, 1'b1, 8'd1, 16'd0);
    run_to(5);  ack[0] = 1'b1;
    run_to(7);  chk("t2_trg_c7", 32'(trg), 32'h003);
    run_to(8);  chk("t2_trg_c8", 32'(trg), 32'h002);
    run_to(20); ack[1] = 1'b1;
    run_to(22); chk("t2_trg_c22", 32'(trg), 32'h002);
    run_to(23); chk("t2_trg_c23", 32'(trg), 0);
    drain("t2_drain");
    ack = '0; idle(5);

    // timeout with one channel missing
    push(3, 12'h001, 12'h100, 16'hFFFF);
    go(12'h101, 1'b0, 8'd2, 16'd50);
    run_to(5);  ack[0] = 1'b1;
    run_to(51); chk("t3_done_c51", 32'(done), 0);
    run_to(52); chk("t3_done_c52", 32'(done), 1);
    chk("t3_trg_c52", 32'(trg), 0);
    drain("t3_drain");
    ack = '0; idle(5);

    // ack already high at start is not an edge
    ack = 12'h004; idle(5);
    push(4, 12'h000, 12'h004, 16'hFFFF);
    go(12'h004, 1'b1, 8'd1, 16'd30);
    run_to(10); chk("t4a_trg_c10", 32'(trg), 32'h004);
    run_to(32); chk("t4a_trg_c32", 32'(trg), 0);
    drain("t4a_drain");
    idle(3);

    // same line toggled low then high completes
    push(5, 12'h004, 12'h000, 16'd10);
    go(12'h004, 1'b1, 8'd1, 16'd30);
    run_to(3);  ack = '0;
    run_to(8);  ack = 12'h004;
    run_to(10); chk("t4b_trg_c10", 32'(trg), 32'h004);
    run_to(11); chk("t4b_trg_c11", 32'(trg), 0);
    drain("t4b_drain");
    ack = '0; idle(5);

    // abort mid-pulse: no done, outputs idle next cycle
    go(12'h0FF, 1'b0, 8'd10, 16'd0);
    run_to(3); chk("t5_trg_c3", 32'(trg), 32'h0FF);
    abort = 1'b1;
    run_to(4); abort = 1'b0;
    chk("t5_trg_c4", 32'(trg), 0);
    chk("t5_busy_c4", 32'(busy), 0);
    idle(5);

    // start while busy is ignored
    push(6, 12'h001, 12'h000, 16'd7);
    go(12'h001, 1'b1, 8'd1, 16'd0);
    run_to(2); start = 1'b1; mask = 12'h0F0;
    run_to(3); start = 1'b0;
    run_to(4); chk("t6_trg_c4", 32'(trg), 32'h001);
    run_to(5); ack[0] = 1'b1;
    run_to(8); chk("t6_seen_c8", 32'(seen), 32'h001);
    drain("t6_drain");
    ack = '0; idle(5);

    // empty mask goes straight to done
    push(7, 12'h000, 12'h000, 16'd0);
    go(12'h000, 1'b0, 8'd3, 16'd0);
    chk("t7_trg_c1", 32'(trg), 0);
    chk("t7_busy_c1", 32'(busy), 1);
    run_to(2); chk("t7_busy_c2", 32'(busy), 0);
    drain("t7_drain");
    idle(2);

    // final ack recorded as elapsed count hits timeout
    push(8, 12'h010, 12'h000, 16'd12);
    go(12'h010, 1'b1, 8'd1, 16'd11);
    run_to(10); ack[4] = 1'b1;
    run_to(13); chk("t8_tmo_c13", 32'(tmo), 0);
    drain("t8_drain");
    ack = '0; idle(5);

    // async reset mid-pulse
    go(12'hAAA, 1'b0, 8'd20, 16'd0);
    run_to(5); chk("t9_trg_c5", 32'(trg), 32'hAAA);
    #2 rst_n = 1'b0;
    #1;
    chk("t9_trg_rst", 32'(trg), 0);
    chk("t9_busy_rst", 32'(busy), 0);
    chk("t9_seen_rst", 32'(seen), 0);
    chk("t9_lat_rst", 32'(lat), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(4);
    chk("t9_busy_after", 32'(busy), 0);
    chk("final_queue", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trg_ack_sequencer.md
# trg_ack_sequencer

Parametrised trigger/acknowledge sequencer for the crate's front-end channels. It replaces direct register-driven TRG bits with a hardware-timed sequence: it drives a masked group of trigger lines in pulse or level mode, then collects the asynchronous ACK returns and reports per-channel status, timeout and acknowledge latency. It sits between the Wishbone slave register file and the TRG/ACK board pins, in the BOARD_CLOCK domain.

## Interface
- N_CH, 12, number of trigger/ack channel pairs
- PW_W, 8, width of pulse-width field
- TO_W, 16, width of timeout/latency counters
- SYNC_STAGES, 2, ACK synchroniser depth (≥2)

- BOARD_CLOCK  in  1  single clock, rising edge
- RST  in  1  reset, asynchronous, active-low
- START_I  in  1  one-cycle start strobe
- MASK_I  in  N_CH  channels to trigger; sampled on accepted START_I
- MODE_I  in  1  0 = fixed pulse, 1 = level held until ack; sampled on START_I
- PW_I  in  PW_W  pulse width in cycles (0 treated as 1); sampled on START_I
- TIMEOUT_I  in  TO_W  timeout in cycles from first TRG cycle; 0 disables; sampled on START_I
- ABORT_I  in  1  abandon current sequence
- ACK  in  N_CH  raw asynchronous acknowledge inputs
- TRG  out  N_CH  registered trigger outputs
- BUSY_O  out  1  high outside IDLE
- DONE_O  out  1  one-cycle pulse at sequence end (complete or timeout)
- ACK_SEEN_O  out  N_CH  sticky: channel acknowledged in current/last sequence
- TMO_O  out  N_CH  masked channels not acknowledged at timeout
- LAT_O  out  TO_W  cycles from first TRG cycle to final ack, saturating

## Operation
- Reset: all outputs 0, state IDLE, synchronisers cleared.
- States: IDLE, PULSE, WAIT, DONE.
- IDLE: START_I with MASK_I≠0 latches config, clears ACK_SEEN_O/TMO_O/LAT_O, elapsed counter E=0; MODE_I=0 → PULSE, MODE_I=1 → WAIT. START_I with MASK_I=0 → DONE directly (no TRG, status cleared).
- START_I outside IDLE ignored.
- ACK passes through SYNC_STAGES flops; an ack is counted only on a rising edge of the synchronised signal, so a line already high at START_I is not counted until it falls and rises again.
- Ack edges recorded into ACK_SEEN_O (masked channels only) in PULSE and WAIT; ignored in IDLE and DONE.
- PULSE: TRG = latched mask for max(PW,1) cycles, then → WAIT with TRG=0.
- WAIT, mode 1: TRG[i] = mask[i] & ~ACK_SEEN_O[i]; drops the cycle after its ack is recorded.
- Completion: in WAIT, when ACK_SEEN_O covers mask → DONE; LAT_O = E at that cycle.
- Timeout: in PULSE or WAIT, TIMEOUT≠0 and E reaches TIMEOUT with mask not covered → DONE; TMO_O = mask & ~ACK_SEEN_O; LAT_O = all-ones; TRG forced 0.
- Same-cycle final ack and timeout: ack recorded first, completion wins, TMO_O=0.
- E increments every cycle in PULSE/WAIT, saturates at 2^TO_W−1.
- DONE: DONE_O=1 one cycle, TRG=0, → IDLE.
- ABORT_I (any state except IDLE): → IDLE next cycle, TRG=0, no DONE_O, status outputs hold current values. ABORT_I and START_I together in IDLE: START wins.
- Asynchronous reset mid-sequence: TRG drops immediately, everything returns to reset values.

## Timing
- START_I at cycle 0 → TRG high from cycle 1; BUSY_O high from cycle 1; E=0 at cycle 1.
- Pulse mode: TRG high cycles 1..PW, low from PW+1.
- ACK rising at pin → recorded in ACK_SEEN_O SYNC_STAGES+1 cycles later.
- Completion recorded at cycle c → DONE_O at c+1, BUSY_O low at c+2.
- Next START_I accepted the cycle BUSY_O is low.

## Test plan
- N_CH=12, mask 0x00F, mode 0, PW=4, timeout 0; ACK0..3 rise at cycle 10 → TRG 0x00F cycles 1–4, DONE_O once, ACK_SEEN_O=0x00F, TMO_O=0, LAT_O=E at recording (≈12).
- Mode 1, mask 0x003; ACK0 at cycle 5, ACK1 at cycle 20 → TRG[0] drops ~cycle 8, TRG[1] ~cycle 23, DONE_O after second, LAT_O ≈22.
- Mask 0x101, timeout 50, only ACK0 rises → DONE_O at cycle ~52, TMO_O=0x100, LAT_O=0xFFFF, TRG=0.
- ACK2 held high before START_I, mask 0x004, timeout 30 → not counted, timeout with TMO_O=0x004; repeat with ACK2 toggled low then high → completes.
- ABORT_I at cycle 3 of PW=10 pulse → TRG=0 and BUSY_O=0 next cycle, no DONE_O; START_I during busy ignored; MASK_I=0 start → DONE_O pulse, no TRG.
- Final ack recorded same cycle E reaches TIMEOUT → completion, TMO_O=0; RST low mid-PULSE → TRG=0 immediately.
